// File: rtl/trap_sequencer_pkg.sv
// Shared CSR addresses, mstatus field positions and sequencer states for trap_sequencer.
package trap_sequencer_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        RD_VEC,
        R_STATUS,
        RD_EPC,
        REDIRECT
    } state_e;

endpackage

// File: rtl/trap_sequencer_mstatus_xform.sv
// Pure mstatus rewrite for trap entry (stack MIE into MPIE) and mret (pop MPIE into MIE).
module trap_sequencer_mstatus_xform
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] old_status,
    input  logic            is_mret,
    output logic [XLEN-1:0] new_status_c
);

    always_comb begin
        new_status_c = old_status;
        if (is_mret) begin
            new_status_c[MSTATUS_MIE]  = old_status[MSTATUS_MPIE];
            new_status_c[MSTATUS_MPIE] = 1'b1;
        end else begin
            new_status_c[MSTATUS_MPIE] = old_status[MSTATUS_MIE];
            new_status_c[MSTATUS_MIE]  = 1'b0;
        end
        // Only machine mode exists, so MPP always reads back as M.
        new_status_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_sequencer.sv
// Orders the CSR writes for ecall entry and mret, then hands the new PC to the IFU.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic              trap_is_mret,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              redirect_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  trap_cnt
);

    state_e            state_q, state_d;
    logic              accept;
    logic              mret_q;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   status_new_c;

    logic              wen_d;
    logic [CSR_AW-1:0] waddr_d;
    logic [CSR_AW-1:0] raddr_d;
    logic [XLEN-1:0]   wdata_d;

    assign accept = trap_valid & trap_ready;

    trap_sequencer_mstatus_xform #(.XLEN(XLEN)) u_xform (
        .old_status   (csr_rdata),
        .is_mret      (mret_q),
        .new_status_c (status_new_c)
    );

    // Next state, then the registered CSR controls for the state being entered.
    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        waddr_d = '0;
        raddr_d = '0;
        wdata_d = '0;

        case (state_q)
            IDLE:     if (accept) state_d = trap_is_mret ? R_STATUS : W_EPC;
            W_EPC:    state_d = W_CAUSE;
            W_CAUSE:  state_d = W_STATUS;
            W_STATUS: state_d = RD_VEC;
            RD_VEC:   state_d = REDIRECT;
            R_STATUS: state_d = RD_EPC;
            RD_EPC:   state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        case (state_d)
            W_EPC: begin
                wen_d   = 1'b1;
                waddr_d = CSR_AW'(CSR_MEPC);
                wdata_d = trap_pc;
            end
            W_CAUSE: begin
                wen_d   = 1'b1;
                waddr_d = CSR_AW'(CSR_MCAUSE);
                wdata_d = cause_q;
            end
            W_STATUS, R_STATUS: begin
                wen_d   = 1'b1;
                waddr_d = CSR_AW'(CSR_MSTATUS);
                raddr_d = CSR_AW'(CSR_MSTATUS);
            end
            RD_VEC:  raddr_d = CSR_AW'(CSR_MTVEC);
            RD_EPC:  raddr_d = CSR_AW'(CSR_MEPC);
            default: ;
        endcase
    end

    // mstatus is read-modify-write within one cycle, so its data follows the read port.
    always_comb begin
        csr_wdata = wdata_q;
        if (state_q == W_STATUS || state_q == R_STATUS) csr_wdata = status_new_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            trap_ready     <= 1'b1;
            busy           <= 1'b0;
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_raddr      <= '0;
            wdata_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            trap_cnt       <= '0;
            mret_q         <= 1'b0;
            cause_q        <= '0;
        end else begin
            state_q        <= state_d;
            trap_ready     <= (state_d == IDLE);
            busy           <= (state_d != IDLE);
            csr_wen        <= wen_d;
            csr_waddr      <= waddr_d;
            csr_raddr      <= raddr_d;
            wdata_q        <= wdata_d;
            redirect_valid <= (state_d == REDIRECT);
            if (accept) begin
                mret_q  <= trap_is_mret;
                cause_q <= trap_cause;
                if (!trap_is_mret) trap_cnt <= trap_cnt + CNT_W'(1);
            end
            // Vectored mode is unsupported: the target is always word aligned.
            if (state_q == RD_VEC || state_q == RD_EPC)
                redirect_pc <= {csr_rdata[XLEN-1:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: CSR file model, write log and hand-computed expectations.
module tb_trap_sequencer;

    logic        clock;
    logic        reset;
    logic        trap_valid;
    logic        trap_ready;
    logic        trap_is_mret;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;
    logic [31:0] trap_cnt;

    // Narrow-counter twin run in lockstep to reach the counter wrap quickly.
    logic        s_trap_ready, s_csr_wen, s_redirect_valid, s_busy;
    logic [11:0] s_csr_waddr, s_csr_raddr;
    logic [31:0] s_csr_wdata, s_redirect_pc;
    logic [1:0]  s_trap_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_status, m_tvec, m_epc, m_cause;
    logic        set_en;
    logic [11:0] set_addr;
    logic [31:0] set_data;
    logic [11:0] log_addr[$];
    logic [31:0] log_data[$];
    int          n0;
    logic [31:0] held_pc;

    trap_sequencer #(.XLEN(32), .CSR_AW(12), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_is_mret(trap_is_mret),
        .trap_cause(trap_cause), .trap_pc(trap_pc),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .busy(busy), .trap_cnt(trap_cnt)
    );

    trap_sequencer #(.XLEN(32), .CSR_AW(12), .CNT_W(2)) dut_small (
        .clock(clock), .reset(reset),
        .trap_valid(trap_valid), .trap_ready(s_trap_ready), .trap_is_mret(trap_is_mret),
        .trap_cause(trap_cause), .trap_pc(trap_pc),
        .csr_wen(s_csr_wen), .csr_waddr(s_csr_waddr), .csr_wdata(s_csr_wdata),
        .csr_raddr(s_csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .redirect_ready(redirect_ready),
        .busy(s_busy), .trap_cnt(s_trap_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        case (csr_raddr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = 32'h0;
        endcase
    end

    // CSR file: DUT writes are logged; bench presets go through set_en.
    always @(posedge clock) begin
        if (set_en || csr_wen) begin
            case (set_en ? set_addr : csr_waddr)
                12'h300: m_status <= set_en ? set_data : csr_wdata;
                12'h305: m_tvec   <= set_en ? set_data : csr_wdata;
                12'h341: m_epc    <= set_en ? set_data : csr_wdata;
                12'h342: m_cause  <= set_en ? set_data : csr_wdata;
                default: ;
            endcase
        end
        if (csr_wen) begin
            log_addr.push_back(csr_waddr);
            log_data.push_back(csr_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_set(input logic [11:0] a, input logic [31:0] d);
        set_en = 1'b1; set_addr = a; set_data = d;
        tick();
        set_en = 1'b0;
    endtask

    task automatic wait_redirect();
        for (int i = 0; i < 20 && !redirect_valid; i++) tick();
        check("redirect_timeout", 32'(redirect_valid), 32'd1);
    endtask

    task automatic do_ecall(input logic [31:0] pc);
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_cause = 32'd11; trap_pc = pc;
        tick();
        trap_valid = 1'b0;
        wait_redirect();
        tick();
    endtask

    initial begin
        reset = 1'b1; trap_valid = 1'b0; trap_is_mret = 1'b0; trap_cause = '0; trap_pc = '0;
        redirect_ready = 1'b0; set_en = 1'b0; set_addr = '0; set_data = '0;
        repeat (2) tick();
        check("rst_ready", 32'(trap_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wen", 32'(csr_wen), 32'd0);
        check("rst_waddr", 32'(csr_waddr), 32'd0);
        check("rst_raddr", 32'(csr_raddr), 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        check("rst_rvalid", 32'(redirect_valid), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_cnt", trap_cnt, 32'd0);
        reset = 1'b0;

        // Entry: mstatus 0x8, misaligned mtvec
        csr_set(12'h300, 32'h0000_0008);
        csr_set(12'h305, 32'h8000_0101);
        n0 = log_addr.size();
        redirect_ready = 1'b1;
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_cause = 32'd11; trap_pc = 32'h8000_0040;
        tick();
        trap_valid = 1'b0;
        check("ent_epc_wen", 32'(csr_wen), 32'd1);
        check("ent_epc_addr", 32'(csr_waddr), 32'h341);
        check("ent_epc_data", csr_wdata, 32'h8000_0040);
        check("ent_busy", 32'(busy), 32'd1);
        check("ent_ready", 32'(trap_ready), 32'd0);
        tick();
        check("ent_cause_addr", 32'(csr_waddr), 32'h342);
        check("ent_cause_data", csr_wdata, 32'd11);
        tick();
        check("ent_st_addr", 32'(csr_waddr), 32'h300);
        check("ent_st_raddr", 32'(csr_raddr), 32'h300);
        check("ent_st_data", csr_wdata, 32'h0000_1880);
        tick();
        check("ent_vec_wen", 32'(csr_wen), 32'd0);
        check("ent_vec_raddr", 32'(csr_raddr), 32'h305);
        check("ent_vec_rvalid", 32'(redirect_valid), 32'd0);
        tick();
        check("ent_rvalid", 32'(redirect_valid), 32'd1);
        check("ent_rpc", redirect_pc, 32'h8000_0100);
        check("ent_cnt", trap_cnt, 32'd1);
        tick();
        check("ent_done_rvalid", 32'(redirect_valid), 32'd0);
        check("ent_done_ready", 32'(trap_ready), 32'd1);
        check("ent_done_busy", 32'(busy), 32'd0);
        check("ent_mstatus", m_status, 32'h0000_1880);
        check("ent_nwrites", 32'(log_addr.size() - n0), 32'd3);

        // Return
        csr_set(12'h341, 32'h8000_0044);
        n0 = log_addr.size();
        trap_valid = 1'b1; trap_is_mret = 1'b1;
        tick();
        trap_valid = 1'b0;
        check("ret_wen", 32'(csr_wen), 32'd1);
        check("ret_addr", 32'(csr_waddr), 32'h300);
        check("ret_data", csr_wdata, 32'h0000_1888);
        tick();
        check("ret_epc_wen", 32'(csr_wen), 32'd0);
        check("ret_epc_raddr", 32'(csr_raddr), 32'h341);
        check("ret_epc_rvalid", 32'(redirect_valid), 32'd0);
        tick();
        check("ret_rvalid", 32'(redirect_valid), 32'd1);
        check("ret_rpc", redirect_pc, 32'h8000_0044);
        check("ret_cnt", trap_cnt, 32'd1);
        tick();
        check("ret_nwrites", 32'(log_addr.size() - n0), 32'd1);
        check("ret_mstatus", m_status, 32'h0000_1888);

        // Backpressure with a second request held high throughout
        redirect_ready = 1'b0;
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_cause = 32'd11; trap_pc = 32'h8000_0200;
        tick();
        wait_redirect();
        held_pc = 32'h8000_0100;
        for (int i = 0; i < 6; i++) begin
            check("bp_rvalid", 32'(redirect_valid), 32'd1);
            check("bp_rpc", redirect_pc, held_pc);
            check("bp_ready", 32'(trap_ready), 32'd0);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        check("bp_done_ready", 32'(trap_ready), 32'd1);
        check("bp_done_rvalid", 32'(redirect_valid), 32'd0);
        check("bp_done_busy", 32'(busy), 32'd0);
        check("bp_cnt", trap_cnt, 32'd2);
        trap_valid = 1'b0;

        // Reset while in W_CAUSE
        csr_set(12'h300, 32'h0000_0008);
        n0 = log_addr.size();
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_pc = 32'h8000_0080;
        tick();
        trap_valid = 1'b0;
        tick();
        check("rm_in_cause", 32'(csr_waddr), 32'h342);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_ready", 32'(trap_ready), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_wen", 32'(csr_wen), 32'd0);
        check("rm_rvalid", 32'(redirect_valid), 32'd0);
        check("rm_cnt", trap_cnt, 32'd0);
        repeat (4) tick();
        check("rm_mstatus", m_status, 32'h0000_0008);
        check("rm_mepc", m_epc, 32'h8000_0080);
        check("rm_nwrites", 32'(log_addr.size() - n0), 32'd2);

        // Back-to-back: mret raised in the handshake cycle
        n0 = log_addr.size();
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_cause = 32'd11; trap_pc = 32'h8000_00C0;
        tick();
        trap_valid = 1'b0;
        wait_redirect();
        check("b2b_ent_rpc", redirect_pc, 32'h8000_0100);
        trap_valid = 1'b1; trap_is_mret = 1'b1;
        tick();
        check("b2b_idle_ready", 32'(trap_ready), 32'd1);
        check("b2b_idle_wen", 32'(csr_wen), 32'd0);
        tick();
        trap_valid = 1'b0;
        check("b2b_ret_addr", 32'(csr_waddr), 32'h300);
        check("b2b_ret_data", csr_wdata, 32'h0000_1888);
        tick();
        tick();
        check("b2b_ret_rvalid", 32'(redirect_valid), 32'd1);
        check("b2b_ret_rpc", redirect_pc, 32'h8000_00C0);
        tick();
        check("b2b_nwrites", 32'(log_addr.size() - n0), 32'd4);
        if (log_addr.size() - n0 == 4) begin
            check("b2b_w0", 32'(log_addr[n0]),     32'h341);
            check("b2b_w1", 32'(log_addr[n0 + 1]), 32'h342);
            check("b2b_w2", 32'(log_addr[n0 + 2]), 32'h300);
            check("b2b_w3", 32'(log_addr[n0 + 3]), 32'h300);
            check("b2b_d2", log_data[n0 + 2], 32'h0000_1880);
        end
        check("b2b_cnt", trap_cnt, 32'd1);

        // Counter wrap on the 2-bit twin after four entries
        do_ecall(32'h8000_0300);
        do_ecall(32'h8000_0304);
        check("wrap_small_3", 32'(s_trap_cnt), 32'd3);
        do_ecall(32'h8000_0308);
        check("wrap_small_0", 32'(s_trap_cnt), 32'd0);
        check("wrap_cnt", trap_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
